// File: rtl/lct_l1a_gen.sv
// lct_l1a_gen: self-test burst source issuing PLCT pulses, each followed by an L1A a fixed latency later.
// Optional CLCT echo output (CLCT_ADJ+1 clocks after each PLCT) is enabled by defining LCTGEN_CLCT_EN.
module lct_l1a_gen #(
   parameter int CNT_W = 16,
   parameter int LAT_W = 9,
   parameter int GAP_W = 8,
   parameter int DEPTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             STOP,
   input  logic [CNT_W-1:0] NPULSES,
   input  logic [LAT_W-1:0] LATENCY,
   input  logic [GAP_W-1:0] GAP,
   input  logic [1:0]       L1A_MODE,
`ifdef LCTGEN_CLCT_EN
   input  logic [3:0]       CLCT_ADJ,
   output logic             CLCT,
`endif
   output logic             PLCT,
   output logic             L1A,
   output logic             BUSY,
   output logic             DONE,
   output logic [CNT_W-1:0] LCT_CNT,
   output logic [CNT_W-1:0] L1A_CNT,
   output logic [CNT_W-1:0] STALL_CNT
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   npulses_q, npulses_d;
   logic [LAT_W-1:0]   latency_q, latency_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [1:0]         mode_q, mode_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0]   lct_cnt_q, lct_cnt_d;
   logic [CNT_W-1:0]   l1a_cnt_q, l1a_cnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [LAT_W-1:0]   ts_q, ts_d;
   logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
   logic               plct_q, plct_d;
   logic               l1a_q, l1a_d;
   logic [LAT_W-1:0]   mem_q [DEPTH];

   logic start_acc, q_empty, q_full, pop, due, stall, issue, eligible, push;

   always_comb begin
      start_acc = (state_q == S_IDLE) && START;
      q_empty   = (wr_ptr_q == rd_ptr_q);
      q_full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
      ts_d      = ts_q + 1'b1;
      // Head entry holds the absolute timestamp its L1A is due; equality alone survives wrap.
      pop       = !q_empty && (mem_q[rd_ptr_q[PTR_W-1:0]] == ts_d);
      case (mode_q)
         2'd1:    eligible = 1'b0;
         2'd2:    eligible = !lct_cnt_q[0];
         default: eligible = 1'b1;
      endcase
      due       = (state_q == S_RUN) && !STOP && (lct_cnt_q != npulses_q) && (gap_cnt_q == '0);
      stall     = due && q_full && !pop;
      issue     = due && !stall;
      push      = issue && eligible;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (START) state_d = S_RUN;
         S_RUN:   if (STOP || (lct_cnt_q == npulses_q)) state_d = S_DRAIN;
         S_DRAIN: if (q_empty && !l1a_q) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      npulses_d   = start_acc ? NPULSES : npulses_q;
      latency_d   = latency_q;
      if (start_acc) latency_d = (LATENCY == '0) ? LAT_W'(1) : LATENCY;
      gap_d       = start_acc ? GAP : gap_q;
      mode_d      = start_acc ? L1A_MODE : mode_q;

      gap_cnt_d = gap_cnt_q;
      if (start_acc)               gap_cnt_d = '0;
      else if (issue)              gap_cnt_d = gap_q;
      else if (gap_cnt_q != '0)    gap_cnt_d = gap_cnt_q - 1'b1;

      lct_cnt_d = lct_cnt_q;
      if (start_acc)  lct_cnt_d = '0;
      else if (issue) lct_cnt_d = lct_cnt_q + 1'b1;

      l1a_cnt_d = l1a_cnt_q;
      if (start_acc) l1a_cnt_d = '0;
      else if (pop)  l1a_cnt_d = l1a_cnt_q + 1'b1;

      stall_cnt_d = stall_cnt_q;
      if (start_acc)                          stall_cnt_d = '0;
      else if (stall && (stall_cnt_q != '1))  stall_cnt_d = stall_cnt_q + 1'b1;

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      plct_d   = issue;
      l1a_d    = pop;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         npulses_q   <= '0;
         latency_q   <= '0;
         gap_q       <= '0;
         mode_q      <= '0;
         gap_cnt_q   <= '0;
         lct_cnt_q   <= '0;
         l1a_cnt_q   <= '0;
         stall_cnt_q <= '0;
         ts_q        <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         plct_q      <= 1'b0;
         l1a_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         npulses_q   <= npulses_d;
         latency_q   <= latency_d;
         gap_q       <= gap_d;
         mode_q      <= mode_d;
         gap_cnt_q   <= gap_cnt_d;
         lct_cnt_q   <= lct_cnt_d;
         l1a_cnt_q   <= l1a_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         ts_q        <= ts_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         plct_q      <= plct_d;
         l1a_q       <= l1a_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= ts_d + latency_q;
   end

   // Output logic
   always_comb begin
      BUSY = (state_q != S_IDLE);
      DONE = (state_q == S_DONE);
   end

   assign PLCT      = plct_q;
   assign L1A       = l1a_q;
   assign LCT_CNT   = lct_cnt_q;
   assign L1A_CNT   = l1a_cnt_q;
   assign STALL_CNT = stall_cnt_q;

`ifdef LCTGEN_CLCT_EN
   logic [15:0] clct_sh_q, clct_sh_d;
   logic        clct_q, clct_d;

   // Tap k of the shift line is high k clocks after the PLCT; one more flop gives ADJ+1.
   always_comb begin
      clct_sh_d = {clct_sh_q[14:0], plct_d};
      clct_d    = clct_sh_q[CLCT_ADJ];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         clct_sh_q <= '0;
         clct_q    <= 1'b0;
      end else begin
         clct_sh_q <= clct_sh_d;
         clct_q    <= clct_d;
      end
   end

   assign CLCT = clct_q;
`endif

endmodule

// File: tb/tb_lct_l1a_gen.sv
// Testbench for lct_l1a_gen: directed table, hand-written corner sequences and randomized bursts.
// Define LCTGEN_CLCT_EN to also check the CLCT echo output.
module tb_lct_l1a_gen;
   localparam int CNT_W = 16;
   localparam int LAT_W = 9;
   localparam int GAP_W = 8;
   localparam int DEPTH = 8;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic             START;
   logic             STOP;
   logic [CNT_W-1:0] NPULSES;
   logic [LAT_W-1:0] LATENCY;
   logic [GAP_W-1:0] GAP;
   logic [1:0]       L1A_MODE;
   logic             PLCT, L1A, BUSY, DONE;
   logic [CNT_W-1:0] LCT_CNT, L1A_CNT, STALL_CNT;
`ifdef LCTGEN_CLCT_EN
   logic [3:0]       CLCT_ADJ;
   logic             CLCT;
`endif

   lct_l1a_gen #(.CNT_W(CNT_W), .LAT_W(LAT_W), .GAP_W(GAP_W), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP),
      .NPULSES(NPULSES), .LATENCY(LATENCY), .GAP(GAP), .L1A_MODE(L1A_MODE),
`ifdef LCTGEN_CLCT_EN
      .CLCT_ADJ(CLCT_ADJ), .CLCT(CLCT),
`endif
      .PLCT(PLCT), .L1A(L1A), .BUSY(BUSY), .DONE(DONE),
      .LCT_CNT(LCT_CNT), .L1A_CNT(L1A_CNT), .STALL_CNT(STALL_CNT)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model results, cycle numbers relative to the START edge (cycle 0).
   int m_plct[$];
   int m_l1a[$];
   int m_done;
   int m_stall;

   typedef struct {
      string name;
      int n, lat, gap, mode;
      int e_lct, e_l1a, e_stall, e_done, e_sfirst;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Event-level model: each PLCT goes at its due time unless DEPTH L1As are still outstanding beyond it.
   task automatic model(input int n, input int lat, input int gap, input int mode, input int stop_after);
      int pend[$];
      int due, c, neff, outstanding, drain;
      m_plct.delete();
      m_l1a.delete();
      m_stall = 0;
      if (lat == 0) lat = 1;
      neff = (stop_after > 0 && stop_after < n) ? stop_after : n;
      due = 1;
      for (int k = 0; k < neff; k++) begin
         c = due;
         forever begin
            outstanding = 0;
            foreach (pend[i]) if (pend[i] > c) outstanding++;
            if (outstanding < DEPTH) break;
            c++;
            m_stall++;
         end
         m_plct.push_back(c);
         if (mode != 1 && !(mode == 2 && (k % 2) == 1)) begin
            pend.push_back(c + lat);
            m_l1a.push_back(c + lat);
         end
         due = c + gap + 1;
      end
      drain = (neff == 0) ? 1 : m_plct[m_plct.size()-1] + 1;
      m_done = drain + 1;
      if (m_l1a.size() > 0 && m_l1a[m_l1a.size()-1] + 2 > m_done) m_done = m_l1a[m_l1a.size()-1] + 2;
   endtask

   task automatic run_burst(input string name, input int n, input int lat, input int gap, input int mode,
                            input int stop_after, input int poke, input int sws,
                            input int e_lct, input int e_l1a, input int e_stall, input int e_done,
                            input int e_sfirst);
      bit ep[int];
      bit el[int];
      bit ec[int];
      int last, perr, lerr, derr, berr, cerr, pbad, lbad, seen, sfirst, adj;
      bit exp_bit;
      perr = 0; lerr = 0; derr = 0; berr = 0; cerr = 0; pbad = -1; lbad = -1;
      seen = 0; sfirst = -1; adj = 0;
      model(n, lat, gap, mode, stop_after);
      if (e_lct < 0)   e_lct = m_plct.size();
      if (e_l1a < 0)   e_l1a = m_l1a.size();
      if (e_stall < 0) e_stall = m_stall;
      if (e_done < 0)  e_done = m_done;
      foreach (m_plct[i]) ep[m_plct[i]] = 1'b1;
      foreach (m_l1a[i])  el[m_l1a[i]] = 1'b1;
      last = e_done + 2;
`ifdef LCTGEN_CLCT_EN
      adj = ($urandom_range(0, 1) == 0) ? 5 : int'($urandom_range(0, 15));
      CLCT_ADJ = 4'(adj);
      foreach (m_plct[i]) begin
         ec[m_plct[i] + adj + 1] = 1'b1;
         if (m_plct[i] + adj + 2 > last) last = m_plct[i] + adj + 2;
      end
`endif
      @(negedge CLK);
      NPULSES  = CNT_W'(n);
      LATENCY  = LAT_W'(lat);
      GAP      = GAP_W'(gap);
      L1A_MODE = 2'(mode);
      START    = 1'b1;
      STOP     = (sws != 0);
      @(posedge CLK);
      #1;
      START = 1'b0;
      STOP  = 1'b0;
      if (BUSY !== 1'b1) berr++;
      for (int k = 1; k <= last; k++) begin
         @(posedge CLK);
         #1;
         START = 1'b0;
         STOP  = 1'b0;
         exp_bit = (ep.exists(k) != 0);
         if (PLCT !== exp_bit) begin perr++; if (pbad < 0) pbad = k; end
         exp_bit = (el.exists(k) != 0);
         if (L1A !== exp_bit) begin lerr++; if (lbad < 0) lbad = k; end
         if (DONE !== (k == e_done)) derr++;
         if (BUSY !== (k <= e_done)) berr++;
`ifdef LCTGEN_CLCT_EN
         exp_bit = (ec.exists(k) != 0);
         if (CLCT !== exp_bit) cerr++;
`endif
         if (L1A === 1'b1 && sfirst < 0) sfirst = int'(STALL_CNT);
         if (PLCT === 1'b1) begin
            seen++;
            if (stop_after > 0 && seen == stop_after) STOP = 1'b1;
         end
         if (poke != 0 && k == 3) begin
            START    = 1'b1;
            NPULSES  = CNT_W'(n + 5);
            LATENCY  = LAT_W'(lat + 3);
            GAP      = GAP_W'(gap + 1);
            L1A_MODE = 2'd1;
         end
      end
      check($sformatf("%s/plct_timeline(first bad cycle %0d)", name, pbad), perr, 0);
      check($sformatf("%s/l1a_timeline(first bad cycle %0d)", name, lbad), lerr, 0);
      check($sformatf("%s/done_at_%0d", name, e_done), derr, 0);
      check($sformatf("%s/busy_window", name), berr, 0);
`ifdef LCTGEN_CLCT_EN
      check($sformatf("%s/clct_timeline(adj %0d)", name, adj), cerr, 0);
`endif
      check($sformatf("%s/lct_cnt", name), LCT_CNT, e_lct);
      check($sformatf("%s/l1a_cnt", name), L1A_CNT, e_l1a);
      check($sformatf("%s/stall_cnt", name), STALL_CNT, e_stall);
      if (e_sfirst >= 0) check($sformatf("%s/stall_at_first_l1a", name), sfirst, e_sfirst);
      $display("burst %s: n=%0d lat=%0d gap=%0d mode=%0d -> lct=%0d l1a=%0d stall=%0d done@%0d",
               name, n, lat, gap, mode, LCT_CNT, L1A_CNT, STALL_CNT, e_done);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen, quiet, n, lat, gap, mode, stop_after;

      vecs[0] = '{"spec_basic",   3, 100, 4, 0,  3,  3,  0, 113, -1};
      vecs[1] = '{"spec_stall",  20,  50, 0, 0, 20, 20, 84, 156, 42};
      vecs[2] = '{"spec_mode2",   4,  10, 1, 2,  4,  2,  0,  17, -1};
      vecs[3] = '{"npulses0",     0,   5, 3, 0,  0,  0,  0,   2, -1};
      vecs[4] = '{"mode1",        5,  20, 2, 1,  5,  0,  0,  15, -1};
      vecs[5] = '{"mode3",        2,   7, 0, 3,  2,  2,  0,  11, -1};
      vecs[6] = '{"latency0",     2,   0, 0, 0,  2,  2,  0,   5, -1};
      vecs[7] = '{"full_pushpop", 9,   8, 0, 0,  9,  9,  0,  19, -1};

      RST_N = 1'b0; START = 1'b0; STOP = 1'b0;
      NPULSES = '0; LATENCY = '0; GAP = '0; L1A_MODE = '0;
`ifdef LCTGEN_CLCT_EN
      CLCT_ADJ = 4'd5;
`endif
      repeat (3) @(posedge CLK);
      #1;
      check("reset/outputs_during", {PLCT, L1A, BUSY, DONE}, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      check("reset/pulses_after", {PLCT, L1A, BUSY, DONE}, 0);
      check("reset/counters_after", {LCT_CNT, L1A_CNT, STALL_CNT}, 0);

      for (int i = 0; i < 8; i++)
         run_burst(vecs[i].name, vecs[i].n, vecs[i].lat, vecs[i].gap, vecs[i].mode, 0, 0, 0,
                   vecs[i].e_lct, vecs[i].e_l1a, vecs[i].e_stall, vecs[i].e_done, vecs[i].e_sfirst);

      run_burst("stop_at_3rd", 100, 30, 9, 0, 3, 0, 0, 3, 3, 0, 53, -1);
      run_burst("start_while_busy", 6, 15, 2, 0, 0, 1, 0, 6, 6, 0, 33, -1);
      run_burst("stop_with_start", 3, 100, 4, 0, 0, 0, 1, 3, 3, 0, 113, -1);

      // Reset in the middle of a burst, while the second PLCT is high.
      @(negedge CLK);
      NPULSES = CNT_W'(10); LATENCY = LAT_W'(20); GAP = GAP_W'(2); L1A_MODE = 2'd0;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      seen = 0;
      for (int k = 0; k < 20 && seen < 2; k++) begin
         @(posedge CLK);
         #1;
         if (PLCT === 1'b1) seen++;
      end
      check("rst_mid/plcts_before", seen, 2);
      #1;
      RST_N = 1'b0;
      #1;
      check("rst_mid/plct_l1a_busy_drop", {PLCT, L1A, BUSY}, 0);
      check("rst_mid/lct_cnt_cleared", LCT_CNT, 0);
      @(negedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      quiet = 0;
      repeat (40) begin
         @(posedge CLK);
         #1;
         if (PLCT !== 1'b0 || L1A !== 1'b0 || BUSY !== 1'b0) quiet++;
      end
      check("rst_mid/quiet_after", quiet, 0);
      run_burst("restart", 3, 100, 4, 0, 0, 0, 0, 3, 3, 0, 113, -1);

      for (int r = 0; r < 25; r++) begin
         n    = int'($urandom_range(0, 20));
         lat  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(400, 511)) : int'($urandom_range(0, 80));
         gap  = int'($urandom_range(0, 5));
         mode = int'($urandom_range(0, 3));
         stop_after = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
         run_burst($sformatf("rand%0d", r), n, lat, gap, mode, stop_after, 0, 0, -1, -1, -1, -1, -1);
         repeat ($urandom_range(0, 3)) @(posedge CLK);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
